// File: rtl/rs485_poll_master.sv
// RS485 poll master: sends an 11-bit address frame, then receives two 11-bit
// data frames (low byte first) and reports the reply, a timeout or a frame error.
module rs485_poll_master #(
    parameter int CLKS_PER_BIT = 50,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        poll_req,
    input  logic [7:0]  addr_in,
    input  logic        Rx,
    output logic        Tx,
    output logic        Tx_Enable,
    output logic        busy,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        timeout,
    output logic        frame_err
);

    // state   | meaning
    // IDLE    | waiting for poll_req
    // TX_ADDR | driving the address frame, driver enabled
    // WAIT_LO | bus released, waiting for start bit of low-byte frame
    // RX_LO   | receiving low-byte frame
    // WAIT_HI | waiting for start bit of high-byte frame
    // RX_HI   | receiving high-byte frame
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] TX_ADDR = 3'd1;
    localparam logic [2:0] WAIT_LO = 3'd2;
    localparam logic [2:0] RX_LO   = 3'd3;
    localparam logic [2:0] WAIT_HI = 3'd4;
    localparam logic [2:0] RX_HI   = 3'd5;

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
    // Loaded one short so the pulse lands exactly TIMEOUT_BITS bit periods later.
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BIT  = 4'd10;

    logic [2:0]    state;
    logic [BW-1:0] bit_cnt;
    logic [3:0]    bit_idx;
    logic [TW-1:0] to_cnt;
    logic [10:0]   tx_shift;
    logic [8:0]    rx_shift;
    logic [7:0]    lo_byte;
    logic          rx_s1;
    logic          rx_sync;
    logic          rx_prev;
    logic          rx_fall;
    logic          in_rx_phase;

    assign Tx        = (state == TX_ADDR) ? tx_shift[0] : 1'b1;
    assign Tx_Enable = (state == TX_ADDR);
    assign busy      = (state != IDLE);

    assign rx_fall     = rx_prev & ~rx_sync;
    assign in_rx_phase = (state == WAIT_LO) || (state == RX_LO) ||
                         (state == WAIT_HI) || (state == RX_HI);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= Rx;
            rx_sync <= rx_s1;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            to_cnt     <= '0;
            tx_shift   <= '1;
            rx_shift   <= '0;
            lo_byte    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            timeout    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            timeout    <= 1'b0;
            frame_err  <= 1'b0;

            // Timeout runs through glitch rejection too; only the WAIT states act on it.
            if (in_rx_phase && (to_cnt != '0)) begin
                to_cnt <= to_cnt - TW'(1);
            end

            case (state)
                IDLE: begin
                    if (poll_req) begin
                        tx_shift <= {2'b11, addr_in, 1'b0};
                        bit_cnt  <= BIT_LAST;
                        bit_idx  <= '0;
                        state    <= TX_ADDR;
                    end
                end

                TX_ADDR: begin
                    if (bit_cnt == '0) begin
                        bit_cnt <= BIT_LAST;
                        if (bit_idx == LAST_BIT) begin
                            to_cnt <= TO_LAST;
                            state  <= WAIT_LO;
                        end else begin
                            bit_idx  <= bit_idx + 4'd1;
                            tx_shift <= {1'b1, tx_shift[10:1]};
                        end
                    end else begin
                        bit_cnt <= bit_cnt - BW'(1);
                    end
                end

                WAIT_LO, WAIT_HI: begin
                    if (rx_fall) begin
                        bit_cnt <= HALF_LAST;
                        bit_idx <= '0;
                        state   <= (state == WAIT_LO) ? RX_LO : RX_HI;
                    end else if (to_cnt == '0) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end
                end

                RX_LO, RX_HI: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - BW'(1);
                    end else begin
                        bit_cnt <= BIT_LAST;
                        if (bit_idx == 4'd0) begin
                            if (rx_sync) begin
                                state <= (state == RX_LO) ? WAIT_LO : WAIT_HI;
                            end else begin
                                bit_idx <= 4'd1;
                            end
                        end else if (bit_idx == LAST_BIT) begin
                            // rx_shift[8] is the mark bit, rx_sync is the stop bit.
                            if (rx_shift[8] || !rx_sync) begin
                                frame_err <= 1'b1;
                                state     <= IDLE;
                            end else if (state == RX_LO) begin
                                lo_byte <= rx_shift[7:0];
                                to_cnt  <= TO_LAST;
                                state   <= WAIT_HI;
                            end else begin
                                data_out   <= {rx_shift[7:0], lo_byte};
                                data_valid <= 1'b1;
                                state      <= IDLE;
                            end
                        end else begin
                            rx_shift <= {rx_sync, rx_shift[8:1]};
                            bit_idx  <= bit_idx + 4'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
